// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO and an internal baud counter.
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   baud_div    - clocks per bit, latched at frame start (values below 2 act as 2)
//   tx_valid    - write request; a word is accepted when tx_valid && tx_ready
//   tx_data     - word to transmit
//   tx_ready    - FIFO can accept a word
//   tx_serial   - UART line, idle high
//   tx_busy     - frame in progress or FIFO holds words
//   fifo_level  - number of words held in the FIFO
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   per_q, per_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   serial_q, serial_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   start_frame;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   head;

  // FIFO storage; contents are never reset and only read behind the level count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Next-state, FIFO bookkeeping and line value
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    serial_d    = serial_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    push    = tx_valid && ready_q;
    head    = mem_q[rd_ptr_q];
    bit_end = (cnt_q == per_q - DIV_WIDTH'(1));

    // Bit-period counter runs in every non-idle state and wraps at each bit boundary
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        // level_q excludes a word pushed on this edge, so it waits one cycle
        if (level_q != '0) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d  = ST_DATA;
          bit_d    = '0;
          serial_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d  = ST_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = ST_STOP;
              stop_d   = 1'b0;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d  = ST_STOP;
          stop_d   = 1'b0;
          serial_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when words are waiting
            if (level_q != '0) begin
              start_frame = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              serial_d = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Pop head word, latch divisor and parity, drive the start bit
    if (start_frame) begin
      pop      = 1'b1;
      state_d  = ST_START;
      serial_d = 1'b0;
      cnt_d    = '0;
      per_d    = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
      shift_d  = head;
      par_d    = (PARITY == 1) ? ~(^head) : ^head;
      bit_d    = '0;
      stop_d   = 1'b0;
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ready_d  = (level_d != LVL_W'(FIFO_DEPTH));
    busy_d   = (state_d != ST_IDLE) || (level_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      per_q    <= DIV_WIDTH'(2);
      shift_q  <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_ready   = ready_q;
  assign tx_serial  = serial_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 default instance plus even/odd parity instances.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        valid_m, valid_e, valid_o;
  logic        ready_m, ready_e, ready_o;
  logic        ser_m, ser_e, ser_o;
  logic        busy_m, busy_e, busy_o;
  logic [2:0]  lvl_m, lvl_e, lvl_o;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo u_main (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_valid(valid_m), .tx_data(tx_data),
    .tx_ready(ready_m), .tx_serial(ser_m), .tx_busy(busy_m), .fifo_level(lvl_m)
  );

  uart_tx_fifo #(.PARITY(2)) u_even (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_valid(valid_e), .tx_data(tx_data),
    .tx_ready(ready_e), .tx_serial(ser_e), .tx_busy(busy_e), .fifo_level(lvl_e)
  );

  uart_tx_fifo #(.PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_valid(valid_o), .tx_data(tx_data),
    .tx_ready(ready_o), .tx_serial(ser_o), .tx_busy(busy_o), .fifo_level(lvl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ser(input int sel);
    return (sel == 0) ? ser_m : (sel == 1) ? ser_e : ser_o;
  endfunction

  // 8N1 frame in transmission order: bit0 start, bits1..8 data LSB first, bit9 stop
  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return 16'h0200 | (16'(d) << 1);
  endfunction

  // Check every clock of a frame; sample j is the negedge after (pop edge + j)
  task automatic expect_frame(input int sel, input logic [15:0] vec, input int nbits,
                              input int p, input int first_j, input bit here, input string tag);
    logic [15:0] v;
    v = vec;
    for (int j = first_j; j < nbits * p; j++) begin
      if (j != first_j || !here) @(negedge clk);
      chk(tag, 32'(ser(sel)), 32'(v[j / p]));
    end
  endtask

  task automatic push1(input int sel, input logic [7:0] d);
    tx_data = d;
    if (sel == 0) valid_m = 1'b1;
    else if (sel == 1) valid_e = 1'b1;
    else valid_o = 1'b1;
    @(negedge clk);
    valid_m = 1'b0;
    valid_e = 1'b0;
    valid_o = 1'b0;
  endtask

  initial begin
    logic [2:0] fill_lvl [8];
    fill_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};

    rst_n    = 1'b0;
    valid_m  = 1'b0;
    valid_e  = 1'b0;
    valid_o  = 1'b0;
    baud_div = 16'd4;
    tx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_serial", 32'(ser_m), 32'd1);
    chk("rst_ready", 32'(ready_m), 32'd1);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_level", 32'(lvl_m), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, P=4, 0x41
    push1(0, 8'h41);
    chk("push_level", 32'(lvl_m), 32'd1);
    chk("push_busy", 32'(busy_m), 32'd1);
    chk("no_same_cycle_pop", 32'(ser_m), 32'd1);
    expect_frame(0, 16'h0282, 10, 4, 0, 1'b0, "frame_41");
    chk("busy_last_stop", 32'(busy_m), 32'd1);
    @(negedge clk);
    chk("busy_after_41", 32'(busy_m), 32'd0);
    chk("idle_after_41", 32'(ser_m), 32'd1);

    // Parity: 0x07 has three ones -> even parity 1, odd parity 0
    push1(1, 8'h07);
    expect_frame(1, 16'h060E, 11, 4, 0, 1'b0, "even_07");
    @(negedge clk);
    chk("busy_after_even", 32'(busy_e), 32'd0);
    push1(2, 8'h07);
    expect_frame(2, 16'h040E, 11, 4, 0, 1'b0, "odd_07");
    @(negedge clk);
    chk("busy_after_odd", 32'(busy_o), 32'd0);

    // FIFO fill: valid held 8 cycles at P=100, five words accepted
    baud_div = 16'd100;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'h30 + 8'(i);
      valid_m = 1'b1;
      @(negedge clk);
      chk("fill_level", 32'(lvl_m), 32'(fill_lvl[i]));
      chk("fill_ready", 32'(ready_m), (i < 4) ? 32'd1 : 32'd0);
    end
    valid_m = 1'b0;
    expect_frame(0, f8n1(8'h30), 10, 100, 6, 1'b1, "order_30");
    expect_frame(0, f8n1(8'h31), 10, 100, 0, 1'b0, "order_31");
    expect_frame(0, f8n1(8'h32), 10, 100, 0, 1'b0, "order_32");
    expect_frame(0, f8n1(8'h33), 10, 100, 0, 1'b0, "order_33");
    expect_frame(0, f8n1(8'h34), 10, 100, 0, 1'b0, "order_34");
    @(negedge clk);
    chk("fill_done_busy", 32'(busy_m), 32'd0);
    chk("fill_done_level", 32'(lvl_m), 32'd0);

    // Back-to-back frames at P=4: 80 clocks with no gap
    baud_div = 16'd4;
    tx_data  = 8'hA5;
    valid_m  = 1'b1;
    @(negedge clk);
    tx_data  = 8'h3C;
    @(negedge clk);
    valid_m  = 1'b0;
    chk("b2b_level", 32'(lvl_m), 32'd1);
    expect_frame(0, f8n1(8'hA5), 10, 4, 0, 1'b1, "b2b_A5");
    expect_frame(0, f8n1(8'h3C), 10, 4, 0, 1'b0, "b2b_3C");
    @(negedge clk);
    chk("b2b_busy", 32'(busy_m), 32'd0);

    // Divisor change after latch: current frame P=4, next P=8
    tx_data  = 8'h5A;
    valid_m  = 1'b1;
    @(negedge clk);
    tx_data  = 8'hC3;
    @(negedge clk);
    valid_m  = 1'b0;
    baud_div = 16'd8;
    expect_frame(0, f8n1(8'h5A), 10, 4, 0, 1'b1, "div_keep_5A");
    expect_frame(0, f8n1(8'hC3), 10, 8, 0, 1'b0, "div_new_C3");
    @(negedge clk);
    chk("div_busy", 32'(busy_m), 32'd0);

    // Divisor 0 and 1 both give P=2
    baud_div = 16'd0;
    push1(0, 8'h55);
    expect_frame(0, f8n1(8'h55), 10, 2, 0, 1'b0, "div0_55");
    @(negedge clk);
    baud_div = 16'd1;
    push1(0, 8'hA3);
    expect_frame(0, f8n1(8'hA3), 10, 2, 0, 1'b0, "div1_A3");
    @(negedge clk);
    chk("div1_busy", 32'(busy_m), 32'd0);

    // Reset mid-DATA with three words queued
    baud_div = 16'd4;
    valid_m  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'h11 * 8'(i + 1);
      @(negedge clk);
    end
    valid_m = 1'b0;
    chk("rst_q_level", 32'(lvl_m), 32'd3);
    repeat (4) @(negedge clk);
    chk("rst_q_busy", 32'(busy_m), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", 32'(ser_m), 32'd1);
    chk("mid_rst_level", 32'(lvl_m), 32'd0);
    chk("mid_rst_ready", 32'(ready_m), 32'd1);
    chk("mid_rst_busy", 32'(busy_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(ser_m), 32'd1);
    end
    chk("post_rst_busy", 32'(busy_m), 32'd0);
    chk("post_rst_level", 32'(lvl_m), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
